// File: rtl/frac_rate_mult_if.sv
// Rate-update handshake bundle for frac_rate_mult: one write request carrying
// a channel number and a new rate, back-pressured by RATE_RDY.
interface frac_rate_mult_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 1
);
  logic             RATE_VLD;
  logic             RATE_RDY;
  logic [CW-1:0]    RATE_CH;
  logic [WIDTH-1:0] RATE_DATA;

  modport master (
    output RATE_VLD,
    output RATE_CH,
    output RATE_DATA,
    input  RATE_RDY
  );

  modport slave (
    input  RATE_VLD,
    input  RATE_CH,
    input  RATE_DATA,
    output RATE_RDY
  );
endinterface

// File: rtl/frac_rate_mult.sv
// Multi-channel binary rate multiplier: a shared step counter drives CHANNELS
// pulse outputs, each emitting ACTIVE[ch] pulses per 2^WIDTH steps.
module frac_rate_mult #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CK,
  input  logic                RN,
  input  logic                START,
  input  logic                STOP,
  input  logic                ONE_SHOT,
  input  logic                EN,
  frac_rate_mult_if.slave     rate,
  output logic [CHANNELS-1:0] Z,
  output logic                WRAP,
  output logic                BUSY,
  output logic [WIDTH-1:0]    CNT
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          r_state;
  logic [WIDTH-1:0]    r_cnt;
  logic [CHANNELS-1:0] r_z;
  logic                r_wrap;
  logic [WIDTH-1:0]    r_active [CHANNELS];
  logic                r_pendValid;
  logic [CW-1:0]       r_pendCh;
  logic [WIDTH-1:0]    r_pendData;

  logic                w_step;
  logic                w_wrapStep;
  logic                w_commit;
  logic                w_accept;
  logic                w_chOk;
  logic [WIDTH-1:0]    w_next;
  logic [WIDTH-1:0]    w_lsb;
  logic [CHANNELS-1:0] w_zNext;

  assign w_next     = r_cnt + 1'b1;
  // Isolates the lowest set bit of the next count; zero on the wrap step.
  assign w_lsb      = w_next & (~w_next + 1'b1);
  assign w_step     = (r_state == S_RUN) && !STOP && EN;
  assign w_wrapStep = w_step && (w_next == '0);
  assign w_commit   = r_pendValid && ((r_state == S_IDLE) || w_wrapStep);
  assign w_accept   = rate.RATE_VLD && !r_pendValid;

  always_comb begin
    w_chOk = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rate.RATE_CH == CW'(c)) w_chOk = 1'b1;
    end
  end

  // Lowest set bit k of the count selects rate bit WIDTH-1-k, so rate bit j
  // fires on 2^j distinct counts per period.
  always_comb begin
    w_zNext = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (w_lsb[b] && r_active[c][WIDTH-1-b]) w_zNext[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_z     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_z    <= '0;
          r_wrap <= 1'b0;
          if (START && !STOP) r_state <= S_RUN;
        end
        S_RUN: begin
          if (STOP) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_z     <= '0;
            r_wrap  <= 1'b0;
          end else if (EN) begin
            r_cnt  <= w_next;
            r_z    <= w_zNext;
            r_wrap <= (w_next == '0);
            if ((w_next == '0) && ONE_SHOT) r_state <= S_IDLE;
          end else begin
            r_z    <= '0;
            r_wrap <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Out-of-range channel writes are swallowed without occupying the slot.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_pendValid <= 1'b0;
      r_pendCh    <= '0;
      r_pendData  <= '0;
      for (int c = 0; c < CHANNELS; c++) r_active[c] <= '0;
    end else if (w_commit) begin
      r_pendValid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_pendCh == CW'(c)) r_active[c] <= r_pendData;
      end
    end else if (w_accept && w_chOk) begin
      r_pendValid <= 1'b1;
      r_pendCh    <= rate.RATE_CH;
      r_pendData  <= rate.RATE_DATA;
    end
  end

  assign rate.RATE_RDY = !r_pendValid;
  assign Z             = r_z;
  assign WRAP          = r_wrap;
  assign BUSY          = (r_state == S_RUN);
  assign CNT           = r_cnt;

endmodule

// File: tb/tb_frac_rate_mult.sv
// Self-checking bench for frac_rate_mult: directed scenarios plus random
// traffic, compared every cycle against an arithmetic reference model.
module tb_frac_rate_mult;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int CW       = 2;
  localparam int PERIOD   = 1 << WIDTH;

  logic                CK = 1'b0;
  logic                RN = 1'b1;
  logic                START = 1'b0;
  logic                STOP = 1'b0;
  logic                ONE_SHOT = 1'b0;
  logic                EN = 1'b0;
  logic [CHANNELS-1:0] Z;
  logic                WRAP;
  logic                BUSY;
  logic [WIDTH-1:0]    CNT;
  logic [3:0]          enPat = 4'b1001;

  frac_rate_mult_if #(.WIDTH(WIDTH), .CW(CW)) rif ();

  frac_rate_mult #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CW(CW)) dut (
    .CK       (CK),
    .RN       (RN),
    .START    (START),
    .STOP     (STOP),
    .ONE_SHOT (ONE_SHOT),
    .EN       (EN),
    .rate     (rif),
    .Z        (Z),
    .WRAP     (WRAP),
    .BUSY     (BUSY),
    .CNT      (CNT)
  );

  always #5 CK = ~CK;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit                  mRun;
  int                  mCnt;
  int                  mActive [CHANNELS];
  bit                  mPendValid;
  int                  mPendCh;
  int                  mPendData;
  logic [CHANNELS-1:0] mZ;
  bit                  mWrap;

  // A rate bit j is worth 2^j pulses: it fires on counts whose trailing-zero
  // count is WIDTH-1-j.
  function automatic bit pulseAt(input int rateVal, input int n);
    int k;
    int m;
    if (n == 0) return 1'b0;
    k = 0;
    m = n;
    while (m % 2 == 0) begin
      m = m / 2;
      k++;
    end
    return ((rateVal >> (WIDTH - 1 - k)) & 1) != 0;
  endfunction

  task automatic modelReset();
    mRun = 0;
    mCnt = 0;
    mPendValid = 0;
    mPendCh = 0;
    mPendData = 0;
    mZ = '0;
    mWrap = 0;
    for (int c = 0; c < CHANNELS; c++) mActive[c] = 0;
  endtask

  task automatic modelEdge();
    bit preRun;
    bit rdy;
    bit wrapStep;
    int n;
    preRun = mRun;
    rdy = !mPendValid;
    wrapStep = 0;
    if (!mRun) begin
      mZ = '0;
      mWrap = 0;
      mCnt = 0;
      if (START && !STOP) mRun = 1;
    end else if (STOP) begin
      mRun = 0;
      mCnt = 0;
      mZ = '0;
      mWrap = 0;
    end else if (EN) begin
      n = (mCnt + 1) % PERIOD;
      mCnt = n;
      mWrap = (n == 0);
      wrapStep = (n == 0);
      for (int c = 0; c < CHANNELS; c++) mZ[c] = pulseAt(mActive[c], n);
      if (n == 0 && ONE_SHOT) mRun = 0;
    end else begin
      mZ = '0;
      mWrap = 0;
    end
    if (mPendValid && (!preRun || wrapStep)) begin
      mActive[mPendCh] = mPendData;
      mPendValid = 0;
    end else if (rif.RATE_VLD && rdy && (int'(rif.RATE_CH) < CHANNELS)) begin
      mPendValid = 1;
      mPendCh = int'(rif.RATE_CH);
      mPendData = int'(rif.RATE_DATA);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("CNT", 32'(CNT), mCnt);
    checkOutput("Z", 32'(Z), 32'(mZ));
    checkOutput("WRAP", 32'(WRAP), 32'(mWrap));
    checkOutput("BUSY", 32'(BUSY), 32'(mRun));
    checkOutput("RATE_RDY", 32'(rif.RATE_RDY), 32'(!mPendValid));
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic oneShot,
                               input logic en, input logic vld, input logic [CW-1:0] ch,
                               input logic [WIDTH-1:0] data);
    START = start;
    STOP = stop;
    ONE_SHOT = oneShot;
    EN = en;
    rif.RATE_VLD = vld;
    rif.RATE_CH = ch;
    rif.RATE_DATA = data;
  endtask

  task automatic tick();
    @(posedge CK);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic writeIdle(input logic [CW-1:0] ch, input logic [WIDTH-1:0] data);
    applyStimulus(0, 0, 0, 0, 1, ch, data);
    tick();
    applyStimulus(0, 0, 0, 0, 0, '0, '0);
    tick();
  endtask

  task automatic runUntilWrap(input bit usePattern, output int z0Mask, output int z0Cnt,
                              output int z1Cnt, output int zLow);
    bit done;
    done = 0;
    z0Mask = 0;
    z0Cnt = 0;
    z1Cnt = 0;
    zLow = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      EN = usePattern ? enPat[i % 4] : 1'b1;
      tick();
      if (Z[0]) begin
        z0Mask |= (1 << CNT);
        z0Cnt++;
      end
      if (Z[1]) z1Cnt++;
      if (!EN && Z != '0) zLow++;
      if (WRAP) done = 1;
    end
    checkOutput("wrap reached", 32'(done), 1);
    EN = 1'b1;
  endtask

  initial begin
    int z0Mask, z0Cnt, z1Cnt, zLow;
    bit found;

    rif.RATE_VLD = 1'b0;
    rif.RATE_CH = '0;
    rif.RATE_DATA = '0;
    #1 RN = 1'b0;
    modelReset();
    #2;
    checkAll();
    repeat (2) @(posedge CK);
    #1 RN = 1'b1;

    // Rates 5 and 15 written from IDLE
    applyStimulus(0, 0, 0, 0, 1, 2'd0, 4'd5);
    tick();
    checkOutput("rdy low after idle accept", 32'(rif.RATE_RDY), 0);
    applyStimulus(0, 0, 0, 0, 0, '0, '0);
    tick();
    checkOutput("rdy high after idle commit", 32'(rif.RATE_RDY), 1);
    writeIdle(2'd1, 4'd15);

    // Free-running period
    applyStimulus(1, 0, 0, 1, 0, '0, '0);
    tick();
    checkOutput("no step on start edge", 32'(CNT), 0);
    START = 1'b0;
    runUntilWrap(0, z0Mask, z0Cnt, z1Cnt, zLow);
    checkOutput("rate5 positions", 32'(z0Mask), 32'h4544);
    checkOutput("rate5 count", 32'(z0Cnt), 5);
    checkOutput("rate15 count", 32'(z1Cnt), 15);

    // Rate change in RUN waits for the wrap
    repeat (3) tick();
    checkOutput("cnt before run write", 32'(CNT), 3);
    applyStimulus(0, 0, 0, 1, 1, 2'd0, 4'd1);
    tick();
    rif.RATE_VLD = 1'b0;
    checkOutput("rdy low while pending", 32'(rif.RATE_RDY), 0);
    runUntilWrap(0, z0Mask, z0Cnt, z1Cnt, zLow);
    checkOutput("old rate after write", 32'(z0Mask), 32'h4540);
    checkOutput("rdy high after wrap", 32'(rif.RATE_RDY), 1);
    runUntilWrap(0, z0Mask, z0Cnt, z1Cnt, zLow);
    checkOutput("rate1 positions", 32'(z0Mask), 32'h0100);
    checkOutput("rate1 count", 32'(z0Cnt), 1);

    // STOP at CNT=7 with a pending write to ch1
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (CNT == 4'd6) found = 1;
      else tick();
    end
    checkOutput("reached cnt 6", 32'(found), 1);
    applyStimulus(0, 0, 0, 1, 1, 2'd1, 4'd9);
    tick();
    checkOutput("cnt at stop", 32'(CNT), 7);
    applyStimulus(0, 1, 0, 1, 0, '0, '0);
    tick();
    checkOutput("stop cnt", 32'(CNT), 0);
    checkOutput("stop busy", 32'(BUSY), 0);
    checkOutput("stop z", 32'(Z), 0);
    checkOutput("stop rdy pending", 32'(rif.RATE_RDY), 0);
    STOP = 1'b0;
    tick();
    checkOutput("rdy after stop commit", 32'(rif.RATE_RDY), 1);

    // One-shot period at rate 15, twice
    writeIdle(2'd1, 4'd15);
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(1, 0, 1, 1, 0, '0, '0);
      tick();
      START = 1'b0;
      runUntilWrap(0, z0Mask, z0Cnt, z1Cnt, zLow);
      checkOutput("one-shot rate15 count", 32'(z1Cnt), 15);
      checkOutput("one-shot busy drop", 32'(BUSY), 0);
      repeat (3) tick();
    end

    // EN pattern 1,0,0,1 at rate 5
    writeIdle(2'd0, 4'd5);
    applyStimulus(1, 0, 0, 1, 0, '0, '0);
    tick();
    START = 1'b0;
    runUntilWrap(1, z0Mask, z0Cnt, z1Cnt, zLow);
    checkOutput("gated rate5 positions", 32'(z0Mask), 32'h4544);
    checkOutput("gated rate5 count", 32'(z0Cnt), 5);
    checkOutput("z while en low", 32'(zLow), 0);

    // Asynchronous reset mid-period with a pending write
    repeat (3) tick();
    applyStimulus(0, 0, 0, 1, 1, 2'd0, 4'd7);
    tick();
    rif.RATE_VLD = 1'b0;
    #2 RN = 1'b0;
    modelReset();
    #1;
    checkAll();
    checkOutput("reset busy", 32'(BUSY), 0);
    checkOutput("reset rdy", 32'(rif.RATE_RDY), 1);
    @(posedge CK);
    #1;
    checkAll();
    RN = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 2'd3, 4'd7);
    tick();
    checkOutput("rdy after bad channel", 32'(rif.RATE_RDY), 1);
    applyStimulus(1, 0, 0, 1, 0, '0, '0);
    tick();
    START = 1'b0;
    runUntilWrap(0, z0Mask, z0Cnt, z1Cnt, zLow);
    checkOutput("ch0 cleared by reset", 32'(z0Cnt), 0);
    checkOutput("ch1 cleared by reset", 32'(z1Cnt), 0);
    applyStimulus(0, 1, 0, 0, 0, '0, '0);
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0, CW'($urandom_range(0, 3)),
                    WIDTH'($urandom_range(0, PERIOD - 1)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/frac_rate_mult.md
# frac_rate_mult

Parametrised multi-channel binary rate multiplier: one shared WIDTH-bit step counter drives CHANNELS independent pulse outputs. Over each full period of 2^WIDTH count steps, channel ch emits exactly RATE[ch] single-cycle pulses. It extends the fixed 16-bit, single-output, ungated fractional multiplier benchmark with:
- width and channel generics;
- run/stop control with one-shot mode;
- a glitch-free rate-update handshake that commits at period boundaries.

## Interface
Parameters:
- WIDTH, 16, counter and rate width (≥2)
- CHANNELS, 2, number of pulse outputs (≥1)
- CW, max(1, clog2(CHANNELS)), channel-select width

Ports:
- CK  in  1  clock, rising edge
- RN  in  1  reset; asynchronous, active-low
- START  in  1  begin counting, sampled in IDLE
- STOP  in  1  abort to IDLE, clear counter
- ONE_SHOT  in  1  1 = stop after one full period
- EN  in  1  step enable; 0 stalls the counter in RUN
- RATE_VLD  in  1  rate write request
- RATE_RDY  out  1  rate write slot free
- RATE_CH  in  CW  target channel
- RATE_DATA  in  WIDTH  new rate, unsigned
- Z  out  CHANNELS  per-channel pulse, registered
- WRAP  out  1  registered pulse on period end
- BUSY  out  1  state == RUN
- CNT  out  WIDTH  current counter value

## Operation
State machine, registers 0 on RN low:
- IDLE: counter held at 0, no pulses. START=1 and STOP=0 → RUN.
- RUN: on each edge with EN=1 a step occurs.
  - STOP=1 → IDLE; counter cleared; no pulse or WRAP for that edge.
  - A step producing n=0 with ONE_SHOT=1 (sampled on that edge) → IDLE.

Step rules, for each step with n = (CNT+1) mod 2^WIDTH:
- CNT ← n.
- If n≠0: let k = index of the lowest set bit of n. Then Z[ch] ← ACTIVE[ch][WIDTH-1-k].
- If n=0: Z ← 0 and WRAP ← 1.
- On non-step edges: Z ← 0 and WRAP ← 0.
- Over one full period, channel ch pulses exactly ACTIVE[ch] times. No width growth and no saturation.

Rate path:
- One shared pending slot: PEND_VALID, PEND_CH, PEND_DATA.
- RATE_RDY = !PEND_VALID (combinational).
- Accept on an edge with RATE_VLD & RATE_RDY. RATE_CH ≥ CHANNELS is accepted and discarded; PEND_VALID stays 0.
- Commit ACTIVE[PEND_CH] ← PEND_DATA and clear PEND_VALID:
  - on the wrap step (n=0), or
  - on any edge where the state is IDLE at that edge.
- The wrap step itself always uses the old ACTIVE values, so no mid-period rate change is possible.
- Accept and commit never coincide, because RDY is 0 while pending.

Reset values:
- CNT=0, Z=0, WRAP=0, BUSY=0, RATE_RDY=1.
- ACTIVE all 0, PEND_VALID=0, state IDLE.
- Reset mid-period discards pending data and the partial period.

## Timing
- Z, WRAP and CNT update on the same edge. Z[ch] is high for exactly the one cycle in which CNT shows the n that produced it.
- START at edge t: BUSY high after t. The first step is possible at edge t+1 (if EN=1). No step occurs on the START edge.
- EN=0 in RUN: CNT holds and Z=0. Pulse count per period is unaffected; the period simply stretches.
- STOP has priority over START, EN and WRAP. START in RUN is ignored.
- Rate write latency:
  - In IDLE: accepted at edge t, active after t+1; RATE_RDY high again after t+1.
  - In RUN: active from the first step after the next wrap.
- Free run (ONE_SHOT=0): the period repeats indefinitely. WRAP pulses every 2^WIDTH steps.

## Test plan
- WIDTH=4, CHANNELS=2, ACTIVE[0]=5, ACTIVE[1]=15; START with EN=1.
  - Z[0] pulses at CNT=2,6,8,10,14 (5 pulses).
  - Z[1] pulses at every CNT≠0 (15 pulses).
  - WRAP at CNT=0 after 16 steps; pattern repeats.
- Write RATE_CH=0, RATE_DATA=1 at CNT=3 in RUN.
  - RATE_RDY low until the wrap edge.
  - Remainder of the period still follows rate 5.
  - Next period: a single Z[0] pulse at CNT=8.
- ONE_SHOT=1, rate 15: exactly 15 pulses, WRAP once, BUSY drops on the wrap edge. START again → a second identical period.
- EN toggled 1,0,0,1 in a repeating pattern for a full period with rate 5: still 5 pulses at the same CNT values; Z never high while EN=0.
- STOP at CNT=7 with a pending write to ch1: CNT=0, BUSY=0, no pulse on that edge, pending value committed the next edge, RATE_RDY back to 1.
- RN asserted mid-period with a pending write: all outputs and ACTIVE return to 0 immediately; RATE_RDY=1. A write with RATE_CH=3 (CHANNELS=2) is accepted and leaves ACTIVE unchanged.
